// File: rtl/msk_frame_sync.sv
// msk_frame_sync: bit-level frame synchronizer for the MSK receive chain.
// Hunts for SYNC_WORD (or its complement) within MAX_ERR bit errors, then
// packs PAYLOAD_BYTES of payload MSB-first into bytes with SOF/EOF markers.
//
//  state      | meaning
//  -----------+--------------------------------------------------------------
//  ST_SEARCH  | shifting bits into r_sr, testing each window against the sync
//  ST_PAYLOAD | sync found; de-inverting and packing payload bits into bytes

module msk_frame_sync #(
    parameter int                 SYNC_W        = 32,
    parameter logic [SYNC_W-1:0]  SYNC_WORD     = 32'h1ACF_FC1D,
    parameter int                 MAX_ERR       = 2,
    parameter int                 PAYLOAD_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_i,
    input  logic        data_val_i,
    output logic [7:0]  byte_o,
    output logic        byte_val_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic        sync_det_o,
    output logic        inverted_o,
    output logic        locked_o,
    output logic [15:0] frame_cnt_o
);

    localparam int FW  = $clog2(SYNC_W + 1);
    localparam int BCW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    // A normal and an inverted match must never both be possible.
    generate
        if (MAX_ERR >= SYNC_W / 2 || MAX_ERR < 0 || SYNC_W < 8 || SYNC_W > 64 ||
            PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 4096) begin : g_bad_param
            $error("msk_frame_sync: illegal parameter combination");
        end
    endgenerate

    typedef enum logic {
        ST_SEARCH  = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [SYNC_W-1:0] r_sr;
    logic [FW-1:0]     r_fill;
    logic              r_inv;
    logic [7:0]        r_byte_sr;
    logic [2:0]        r_bit_cnt;
    logic [BCW-1:0]    r_byte_cnt;
    logic [7:0]        r_byte;
    logic              r_byte_val;
    logic              r_sof;
    logic              r_eof;
    logic              r_sync_det;
    logic [15:0]       r_frame_cnt;

    logic [SYNC_W-1:0] w_sr_next;
    logic [SYNC_W-1:0] w_diff;
    logic [FW-1:0]     w_dist;
    logic              w_fill_full;
    logic              w_match_norm;
    logic              w_match_inv;
    logic [7:0]        w_byte_next;
    logic              w_det;
    logic              w_byte_done;
    logic              w_last;

    assign w_sr_next    = {r_sr[SYNC_W-2:0], data_i};
    assign w_diff       = w_sr_next ^ SYNC_WORD;
    // Current bit counts toward the fill, so one short of SYNC_W is enough.
    assign w_fill_full  = (r_fill >= FW'(SYNC_W - 1));
    assign w_match_norm = (w_dist <= FW'(MAX_ERR));
    assign w_match_inv  = (w_dist >= FW'(SYNC_W - MAX_ERR));
    assign w_byte_next  = {r_byte_sr[6:0], data_i ^ r_inv};

    // Hamming distance of the candidate window to the sync word.
    always_comb begin
        w_dist = '0;
        for (int k = 0; k < SYNC_W; k++) begin
            w_dist = w_dist + FW'(w_diff[k]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_SEARCH;
        else     r_state <= w_state_next;
    end

    // Next-state logic and per-bit event decode.
    always_comb begin
        w_state_next = r_state;
        w_det        = 1'b0;
        w_byte_done  = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (data_val_i && w_fill_full && (w_match_norm || w_match_inv)) begin
                    w_det        = 1'b1;
                    w_state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (data_val_i && r_bit_cnt == 3'd7) begin
                    w_byte_done = 1'b1;
                    if (r_byte_cnt == BCW'(PAYLOAD_BYTES - 1)) begin
                        w_last       = 1'b1;
                        w_state_next = ST_SEARCH;
                    end
                end
            end
            default: w_state_next = ST_SEARCH;
        endcase
    end

    // Sync shift register, fill counter, byte packing and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr        <= '0;
            r_fill      <= '0;
            r_inv       <= 1'b0;
            r_byte_sr   <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_byte      <= '0;
            r_byte_val  <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_sync_det  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_byte_val <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_sync_det <= w_det;
            if (data_val_i && r_state == ST_SEARCH) begin
                r_sr <= w_sr_next;
                if (r_fill != FW'(SYNC_W)) r_fill <= r_fill + FW'(1);
                if (w_det) begin
                    r_inv      <= w_match_inv;
                    r_byte_sr  <= '0;
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= '0;
                end
            end
            if (data_val_i && r_state == ST_PAYLOAD) begin
                r_byte_sr <= w_byte_next;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_byte_done) begin
                    r_byte     <= w_byte_next;
                    r_byte_val <= 1'b1;
                    r_sof      <= (r_byte_cnt == '0);
                    r_eof      <= w_last;
                    r_byte_cnt <= r_byte_cnt + BCW'(1);
                end
                // Flushing the window keeps payload bits out of the next search.
                if (w_last) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_sr        <= '0;
                    r_fill      <= '0;
                end
            end
        end
    end

    assign byte_o      = r_byte;
    assign byte_val_o  = r_byte_val;
    assign sof_o       = r_sof;
    assign eof_o       = r_eof;
    assign sync_det_o  = r_sync_det;
    assign inverted_o  = r_inv;
    assign locked_o    = (r_state == ST_PAYLOAD);
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_msk_frame_sync.sv
// Directed testbench for msk_frame_sync with default parameters.

module tb_msk_frame_sync;

    localparam logic [31:0] SYNC = 32'h1ACF_FC1D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_i = 1'b0;
    logic        data_val_i = 1'b0;
    logic [7:0]  byte_o;
    logic        byte_val_o;
    logic        sof_o;
    logic        eof_o;
    logic        sync_det_o;
    logic        inverted_o;
    logic        locked_o;
    logic [15:0] frame_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0]  q_bytes[$];
    int          det_cnt = 0;
    int          bad_strobe = 0;
    logic [15:0] fc_at_eof = '0;
    logic        lk_at_eof = 1'b1;
    bit          use_gaps = 0;

    msk_frame_sync dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .data_val_i  (data_val_i),
        .byte_o      (byte_o),
        .byte_val_o  (byte_val_o),
        .sof_o       (sof_o),
        .eof_o       (eof_o),
        .sync_det_o  (sync_det_o),
        .inverted_o  (inverted_o),
        .locked_o    (locked_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 clk = ~clk;

    // Record strobes just after each edge; flag strobes following an invalid bit.
    always @(posedge clk) begin
        logic v;
        v = data_val_i;
        #1;
        if (byte_val_o) begin
            q_bytes.push_back({sof_o, eof_o, byte_o});
            if (!v) bad_strobe++;
            if (eof_o) begin
                fc_at_eof = frame_cnt_o;
                lk_at_eof = locked_o;
            end
        end
        if (sync_det_o) det_cnt++;
    end

    task automatic clear_mon();
        q_bytes.delete();
        det_cnt    = 0;
        bad_strobe = 0;
        lk_at_eof  = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_val_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        data_val_i = 1'b0;
        idle(2);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic send_bit(input logic b);
        if (use_gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                data_val_i = 1'b0;
                data_i = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        data_i = b;
        data_val_i = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // Sync then bytes 0x00..0x0F; checks the sync pulse timing on the way.
    task automatic send_counting_frame();
        send_word(SYNC, 32);
        @(posedge clk);
        #1;
        n_checks++;
        if (sync_det_o !== 1'b1 || locked_o !== 1'b1) begin
            n_errors++;
            $display("FAIL sync_timing: sync_det=%b locked=%b, need 1 1", sync_det_o, locked_o);
        end
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        idle(3);
    endtask

    task automatic check_counting_frame(input string tag);
        n_checks++;
        if (q_bytes.size() !== 16) begin
            n_errors++;
            $display("FAIL %s_count: got %0d bytes, need 16", tag, q_bytes.size());
        end
        for (int i = 0; i < 16 && i < q_bytes.size(); i++) begin
            logic [9:0] exp;
            exp = {(i == 0), (i == 15), 8'(i)};
            n_checks++;
            if (q_bytes[i] !== exp) begin
                n_errors++;
                $display("FAIL %s_byte%0d: got %h, need %h", tag, i, q_bytes[i], exp);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if ({byte_o, byte_val_o, sof_o, eof_o, sync_det_o, inverted_o, locked_o, frame_cnt_o} !== 30'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: byte=%h val=%b sof=%b eof=%b det=%b inv=%b lk=%b fc=%h, need all 0",
                     byte_o, byte_val_o, sof_o, eof_o, sync_det_o, inverted_o, locked_o, frame_cnt_o);
        end
    endtask

    task automatic test_exact();
        do_reset();
        send_counting_frame();
        check_counting_frame("exact");
        n_checks++;
        if (det_cnt !== 1) begin
            n_errors++;
            $display("FAIL exact_det: got %0d pulses, need 1", det_cnt);
        end
        n_checks++;
        if (frame_cnt_o !== 16'd1 || inverted_o !== 1'b0 || locked_o !== 1'b0) begin
            n_errors++;
            $display("FAIL exact_status: fc=%h inv=%b lk=%b, need 0001 0 0", frame_cnt_o, inverted_o, locked_o);
        end
        n_checks++;
        if (fc_at_eof !== 16'd1 || lk_at_eof !== 1'b0) begin
            n_errors++;
            $display("FAIL exact_eof_cycle: fc=%h lk=%b, need 0001 0", fc_at_eof, lk_at_eof);
        end
    endtask

    task automatic test_bit_errors();
        do_reset();
        send_word(SYNC ^ 32'h0002_0001, 32);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        idle(3);
        n_checks++;
        if (det_cnt !== 1 || q_bytes.size() !== 16 || frame_cnt_o !== 16'd1) begin
            n_errors++;
            $display("FAIL err2_detect: det=%0d bytes=%0d fc=%h, need 1 16 0001",
                     det_cnt, q_bytes.size(), frame_cnt_o);
        end
        do_reset();
        send_word(SYNC ^ 32'h0002_0021, 32);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        idle(3);
        n_checks++;
        if (det_cnt !== 0 || q_bytes.size() !== 0 || frame_cnt_o !== 16'd0) begin
            n_errors++;
            $display("FAIL err3_reject: det=%0d bytes=%0d fc=%h, need 0 0 0000",
                     det_cnt, q_bytes.size(), frame_cnt_o);
        end
    endtask

    task automatic test_inverted();
        do_reset();
        send_word(~SYNC, 32);
        for (int i = 0; i < 16; i++) send_byte(8'h5A);
        idle(3);
        n_checks++;
        if (inverted_o !== 1'b1 || q_bytes.size() !== 16 || frame_cnt_o !== 16'd1) begin
            n_errors++;
            $display("FAIL inv_status: inv=%b bytes=%0d fc=%h, need 1 16 0001",
                     inverted_o, q_bytes.size(), frame_cnt_o);
        end
        for (int i = 0; i < q_bytes.size(); i++) begin
            logic [9:0] exp;
            exp = {(i == 0), (i == 15), 8'hA5};
            n_checks++;
            if (q_bytes[i] !== exp) begin
                n_errors++;
                $display("FAIL inv_byte%0d: got %h, need %h", i, q_bytes[i], exp);
            end
        end
    endtask

    task automatic test_gaps();
        use_gaps = 1;
        do_reset();
        send_counting_frame();
        check_counting_frame("gaps");
        n_checks++;
        if (bad_strobe !== 0 || frame_cnt_o !== 16'd1 || det_cnt !== 1) begin
            n_errors++;
            $display("FAIL gaps_status: bad_strobes=%0d fc=%h det=%0d, need 0 0001 1",
                     bad_strobe, frame_cnt_o, det_cnt);
        end
        do_reset();
        send_word(SYNC, 31);
        idle(3);
        n_checks++;
        if (det_cnt !== 0 || locked_o !== 1'b0) begin
            n_errors++;
            $display("FAIL short_sync: det=%0d lk=%b, need 0 0", det_cnt, locked_o);
        end
        use_gaps = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(SYNC, 32);
        for (int i = 0; i < 5; i++) send_byte(8'(i));
        @(negedge clk);
        rst = 1'b1;
        data_val_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({byte_o, byte_val_o, sof_o, eof_o, sync_det_o, inverted_o, locked_o, frame_cnt_o} !== 30'b0) begin
            n_errors++;
            $display("FAIL midrst_outputs: byte=%h val=%b lk=%b fc=%h, need all 0",
                     byte_o, byte_val_o, locked_o, frame_cnt_o);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        n_checks++;
        if (q_bytes.size() !== 5 || q_bytes[4][8] !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_partial: bytes=%0d, need 5 with no eof", q_bytes.size());
        end
        clear_mon();
        send_counting_frame();
        check_counting_frame("midrst");
        n_checks++;
        if (frame_cnt_o !== 16'd1) begin
            n_errors++;
            $display("FAIL midrst_fc: got %h, need 0001", frame_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p1[16];
        do_reset();
        p1[0] = 8'h1A; p1[1] = 8'hCF; p1[2] = 8'hFC; p1[3] = 8'h1D;
        for (int i = 4; i < 16; i++) p1[i] = 8'(i * 17);
        send_word(SYNC, 32);
        for (int i = 0; i < 16; i++) send_byte(p1[i]);
        send_word(SYNC, 32);
        for (int i = 0; i < 16; i++) send_byte(8'hC3);
        idle(3);
        n_checks++;
        if (det_cnt !== 2 || q_bytes.size() !== 32 || frame_cnt_o !== 16'd2) begin
            n_errors++;
            $display("FAIL b2b_status: det=%0d bytes=%0d fc=%h, need 2 32 0002",
                     det_cnt, q_bytes.size(), frame_cnt_o);
        end
        for (int i = 0; i < 32 && i < q_bytes.size(); i++) begin
            logic [7:0] exp;
            exp = (i < 16) ? p1[i] : 8'hC3;
            n_checks++;
            if (q_bytes[i][7:0] !== exp) begin
                n_errors++;
                $display("FAIL b2b_byte%0d: got %h, need %h", i, q_bytes[i][7:0], exp);
            end
        end
        // Frame counter wrap.
        @(negedge clk);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        @(posedge clk);
        #1;
        n_checks++;
        if (frame_cnt_o !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL wrap_preset: got %h, need ffff", frame_cnt_o);
        end
        send_word(SYNC, 32);
        for (int i = 0; i < 16; i++) send_byte(8'h00);
        idle(3);
        n_checks++;
        if (frame_cnt_o !== 16'h0000) begin
            n_errors++;
            $display("FAIL wrap_fc: got %h, need 0000", frame_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_bit_errors();
        test_inverted();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
